frame_cap32: RTL and testbench
==============================

FRAME_CAP32 -- requirements
Module: frame_cap32

Interface
REQ-001 SHALL have parameter width, default 10, bit width of the time-multiplexed sample.
REQ-002 SHALL have parameter stg, default 5'd0, pipeline stage of the monitored signal; slot index cntadj = (cnt + 33 - stg) mod 32.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port mixed  input  width  time-multiplexed sample, one slot per clock.
REQ-006 SHALL have port cnt  input  5  free-running slot counter, nominally +1 mod 32 per clock.
REQ-007 SHALL have port arm  input  1  request to capture the next full 32-slot frame.
REQ-008 SHALL have port rd_addr  input  5  buffer read index, slot number in octal order 0o00..0o37.
REQ-009 SHALL have port rd_ack  input  1  consumer has read the frame; releases the buffer.
REQ-010 SHALL have port rd_data  output  width  registered buffer contents at rd_addr.
REQ-011 SHALL have port frame_valid  output  1  complete frame held in buffer.
REQ-012 SHALL have port busy  output  1  high in SYNC or CAPTURE.
REQ-013 SHALL have port seq_err  output  1  sticky slot-sequence error flag.
REQ-014 SHALL have port frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-015 SHALL compute cntadj combinationally from cnt and stg as in REQ-002.
REQ-016 SHALL hold a 32-entry x width buffer, written only in SYNC/CAPTURE.
REQ-017 SHALL implement states IDLE, SYNC, CAPTURE, DONE; busy = (SYNC or CAPTURE); frame_valid = DONE.
REQ-018 IDLE: arm=1 -> SYNC and clear seq_err; otherwise stay.
REQ-019 SYNC: when cntadj=0, write buf[0]<=mixed, set expected=1, -> CAPTURE; otherwise wait, no writes.
REQ-020 CAPTURE: each cycle write buf[cntadj]<=mixed; if cntadj==expected, expected<=expected+1.
REQ-021 CAPTURE: if cntadj!=expected, set seq_err=1, write nothing that cycle, -> IDLE (frame discarded, frame_cnt unchanged).
REQ-022 CAPTURE: on in-order write of cntadj=31 -> DONE and frame_cnt<=frame_cnt+1 (mod 256); frame_valid high the following cycle.
REQ-023 DONE: buffer frozen; rd_ack=1 -> IDLE; rd_ack=1 with arm=1 same cycle -> SYNC (seq_err cleared).
REQ-024 arm SHALL be ignored in SYNC, CAPTURE, and in DONE without rd_ack; rd_ack ignored outside DONE.
REQ-025 rd_data SHALL equal buf[rd_addr] sampled at the previous clock edge (1-cycle latency), in every state.
REQ-026 Capture latency: frame_valid rises exactly 32 clocks after the SYNC cycle in which cntadj=0 was seen.
REQ-027 seq_err SHALL stay set until the next accepted arm or reset.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, expected=0, rd_data=0, frame_valid=0, busy=0, seq_err=0, frame_cnt=0, from any state including mid-CAPTURE.
REQ-029 Buffer contents SHALL NOT be cleared by reset; reads after reset return stale data with rd_data still 1-cycle latency.

Verification
REQ-030 stg=0, cnt counting from 0, mixed=cnt*3, arm pulse at cnt=5 -> busy until frame_valid rises 32 clocks after cntadj=0; rd_addr=k returns 3*((k-1) mod 32); frame_cnt=1.
REQ-031 stg=3, mixed=slot tag -> buf[0] captured when cnt=2; frame contents match tags shifted by stg-1.
REQ-032 In CAPTURE, cnt held for one cycle at slot 0o12 -> seq_err=1, state IDLE, frame_valid=0, frame_cnt unchanged; next arm clears seq_err.
REQ-033 DONE with arm=1 and rd_ack=1 same cycle -> SYNC next cycle, frame_valid=0, busy=1; arm alone in DONE -> no change.
REQ-034 rst_n=0 for one cycle mid-CAPTURE at cntadj=0o20 -> all outputs at reset values next cycle; previously written slots readable unchanged.
REQ-035 256 back-to-back arm/rd_ack frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/frame_cap32.sv
// frame_cap32: captures one full 32-slot frame of a time-multiplexed sample
// stream into a local buffer for a consumer to read back at its own pace.
//
// Parameters
//   width : bit width of the time-multiplexed sample
//   stg   : pipeline stage of the monitored signal; the slot owning the
//           current sample is cntadj = (cnt + 33 - stg) mod 32
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   synchronous active-low reset
//   mixed       in   time-multiplexed sample, one slot per clock
//   cnt         in   free-running slot counter (+1 mod 32 per clock)
//   arm         in   request capture of the next full frame
//   rd_addr     in   buffer read index (slot number)
//   rd_ack      in   consumer done with the frame, releases the buffer
//   rd_data     out  buffer contents at rd_addr, one cycle latency
//   frame_valid out  a complete frame is held in the buffer
//   busy        out  waiting for slot 0 or capturing
//   seq_err     out  sticky slot-sequence error
//   frame_cnt   out  completed frame count, wraps 255 -> 0
module frame_cap32 #(
    parameter int unsigned width = 10,
    parameter logic [4:0]  stg   = 5'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] mixed,
    input  logic [4:0]       cnt,
    input  logic             arm,
    input  logic [4:0]       rd_addr,
    input  logic             rd_ack,
    output logic [width-1:0] rd_data,
    output logic             frame_valid,
    output logic             busy,
    output logic             seq_err,
    output logic [7:0]       frame_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StCapture,
        StDone
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       expected_q, expected_d;
    logic             seq_err_q, seq_err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [width-1:0] rd_data_q;

    logic [4:0]       cntadj;
    logic             wr_en;

    logic [width-1:0] frame_buf [32];

    // Modulo-32 arithmetic: +33 is +1 once the 5-bit wrap is applied.
    assign cntadj = cnt + 5'd1 - stg;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        seq_err_d   = seq_err_q;
        frame_cnt_d = frame_cnt_q;
        wr_en       = 1'b0;

        case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d   = StSync;
                    seq_err_d = 1'b0;
                end
            end

            StSync: begin
                // Only start on a frame boundary so the capture is always whole.
                if (cntadj == 5'd0) begin
                    wr_en      = 1'b1;
                    expected_d = 5'd1;
                    state_d    = StCapture;
                end
            end

            StCapture: begin
                if (cntadj == expected_q) begin
                    wr_en      = 1'b1;
                    expected_d = expected_q + 5'd1;
                    if (cntadj == 5'd31) begin
                        state_d     = StDone;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else begin
                    // Out-of-order slot: the partial frame is abandoned and
                    // the offending sample is not written.
                    seq_err_d = 1'b1;
                    state_d   = StIdle;
                end
            end

            StDone: begin
                if (rd_ack) begin
                    if (arm) begin
                        state_d   = StSync;
                        seq_err_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            expected_q  <= 5'd0;
            seq_err_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            seq_err_q   <= seq_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Buffer has no reset so a frame survives a reset for post-mortem reads;
    // a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            frame_buf[cntadj] <= mixed;
        end
    end

    // Read sees the contents before any write on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= frame_buf[rd_addr];
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = (state_q == StDone);
    assign busy        = (state_q == StSync) || (state_q == StCapture);
    assign seq_err     = seq_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_frame_cap32.sv
// Bench for frame_cap32: two instances (stg=0 and stg=3) share one stimulus
// stream. A per-cycle reference model predicts every output; directed phases
// add literal expectations for latency, buffer contents, error and reset.
module tb_frame_cap32;

    localparam int W = 10;
    localparam int MIdle = 0, MSync = 1, MCap = 2, MDone = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] mixed;
    logic [4:0]   cnt;
    logic         arm;
    logic [4:0]   rd_addr;
    logic         rd_ack;

    logic [W-1:0] rd_data0, rd_data3;
    logic         fv0, fv3, busy0, busy3, se0, se3;
    logic [7:0]   fc0, fc3;

    always #5 clk = ~clk;

    frame_cap32 #(.width(W), .stg(5'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mixed(mixed), .cnt(cnt), .arm(arm),
        .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data0),
        .frame_valid(fv0), .busy(busy0), .seq_err(se0), .frame_cnt(fc0)
    );

    frame_cap32 #(.width(W), .stg(5'd3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mixed(mixed), .cnt(cnt), .arm(arm),
        .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data3),
        .frame_valid(fv3), .busy(busy3), .seq_err(se3), .frame_cnt(fc3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model, one entry per instance.
    int m_mode  [2];
    int m_nxt   [2];
    int m_buf   [2][32];
    bit m_known [2][32];
    int m_rd    [2];
    bit m_rdk   [2];
    bit m_seq   [2];
    int m_fcnt  [2];
    bit m_live = 1'b0;

    task automatic model_step(input int i);
        int s;
        int slot;
        int a;
        s    = (i == 0) ? 0 : 3;
        slot = (int'(cnt) + 33 - s) % 32;
        if (!rst_n) begin
            m_mode[i] = MIdle;
            m_nxt[i]  = 0;
            m_rd[i]   = 0;
            m_rdk[i]  = 1'b1;
            m_seq[i]  = 1'b0;
            m_fcnt[i] = 0;
        end else begin
            a         = int'(rd_addr);
            m_rd[i]   = m_buf[i][a];
            m_rdk[i]  = m_known[i][a];
            if (m_mode[i] == MIdle) begin
                if (arm) begin
                    m_mode[i] = MSync;
                    m_seq[i]  = 1'b0;
                end
            end else if (m_mode[i] == MSync) begin
                if (slot == 0) begin
                    m_buf[i][0]   = int'(mixed);
                    m_known[i][0] = 1'b1;
                    m_nxt[i]      = 1;
                    m_mode[i]     = MCap;
                end
            end else if (m_mode[i] == MCap) begin
                if (slot == m_nxt[i]) begin
                    m_buf[i][slot]   = int'(mixed);
                    m_known[i][slot] = 1'b1;
                    m_nxt[i]         = m_nxt[i] + 1;
                    if (slot == 31) begin
                        m_mode[i] = MDone;
                        m_fcnt[i] = (m_fcnt[i] + 1) % 256;
                    end
                end else begin
                    m_seq[i]  = 1'b1;
                    m_mode[i] = MIdle;
                end
            end else begin
                if (rd_ack) begin
                    m_mode[i] = arm ? MSync : MIdle;
                    if (arm) m_seq[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic cmp(input int i, input int rd, input int fv, input int bz,
                       input int se, input int fc);
        if (m_rdk[i]) check($sformatf("s%0d.rd_data", i * 3), rd, m_rd[i]);
        check($sformatf("s%0d.frame_valid", i * 3), fv, int'(m_mode[i] == MDone));
        check($sformatf("s%0d.busy", i * 3), bz,
              int'(m_mode[i] == MSync || m_mode[i] == MCap));
        check($sformatf("s%0d.seq_err", i * 3), se, int'(m_seq[i]));
        check($sformatf("s%0d.frame_cnt", i * 3), fc, m_fcnt[i]);
    endtask

    // Single compare process: update model at the edge, check just after.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        if (!rst_n) m_live = 1'b1;
        #1;
        if (m_live) begin
            cmp(0, int'(rd_data0), int'(fv0), int'(busy0), int'(se0), int'(fc0));
            cmp(1, int'(rd_data3), int'(fv3), int'(busy3), int'(se3), int'(fc3));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int c;
        int e;
        int rise0;
        int rise3;
        int frames;
        bit saw;
        bit prev;
        int r;

        rst_n   = 1'b0;
        arm     = 1'b0;
        rd_ack  = 1'b0;
        rd_addr = 5'd0;
        cnt     = 5'd0;
        mixed   = '0;

        // Reset state.
        tick();
        tick();
        check("rst.fv0", int'(fv0), 0);
        check("rst.busy0", int'(busy0), 0);
        check("rst.se0", int'(se0), 0);
        check("rst.fc0", int'(fc0), 0);
        check("rst.rd0", int'(rd_data0), 0);
        check("rst.busy3", int'(busy3), 0);
        rst_n = 1'b1;

        // Frame capture with mixed = 3*cnt, arm at cnt = 5.
        c = 0; e = -1; rise0 = -1; rise3 = -1;
        for (int n = 0; n < 200 && (rise0 < 0 || rise3 < 0); n++) begin
            cnt   = 5'(c);
            mixed = W'(3 * c);
            arm   = (c == 5 && e < 0);
            tick();
            if (e < 0 && c == 5) e = 0;
            else if (e >= 0) e++;
            if (fv0 && rise0 < 0) rise0 = e;
            if (fv3 && rise3 < 0) rise3 = e;
            c = (c + 1) % 32;
        end
        arm = 1'b0;
        check("latency.s0", rise0, 57);
        check("latency.s3", rise3, 60);

        for (int k = 0; k < 32; k++) begin
            cnt     = 5'(c);
            mixed   = W'(3 * c);
            rd_addr = 5'(k);
            tick();
            check($sformatf("frame.s0[%0d]", k), int'(rd_data0), 3 * ((k + 31) % 32));
            check($sformatf("frame.s3[%0d]", k), int'(rd_data3), 3 * ((k + 2) % 32));
            c = (c + 1) % 32;
        end
        check("frame.fc0", int'(fc0), 1);
        check("frame.fc3", int'(fc3), 1);

        // arm alone in DONE is ignored.
        cnt = 5'(c); arm = 1'b1;
        tick();
        c = (c + 1) % 32; arm = 1'b0;
        check("done_arm.fv0", int'(fv0), 1);
        check("done_arm.busy0", int'(busy0), 0);
        check("done_arm.fv3", int'(fv3), 1);

        // arm + rd_ack in DONE re-arms.
        cnt = 5'(c); arm = 1'b1; rd_ack = 1'b1;
        tick();
        c = (c + 1) % 32; arm = 1'b0; rd_ack = 1'b0;
        check("rearm.fv0", int'(fv0), 0);
        check("rearm.busy0", int'(busy0), 1);
        check("rearm.fv3", int'(fv3), 0);
        check("rearm.busy3", int'(busy3), 1);

        // cnt held at 9 (slot 0o12 for stg=0) mid-capture.
        saw = 1'b0;
        for (int n = 0; n < 100; n++) begin
            cnt   = 5'(c);
            mixed = W'(3 * c);
            tick();
            if (saw && c == 9) begin
                tick();
                c = (c + 1) % 32;
                break;
            end
            if (c == 31) saw = 1'b1;
            c = (c + 1) % 32;
        end
        check("glitch.se0", int'(se0), 1);
        check("glitch.busy0", int'(busy0), 0);
        check("glitch.fv0", int'(fv0), 0);
        check("glitch.fc0", int'(fc0), 1);

        cnt = 5'(c); arm = 1'b1;
        tick();
        c = (c + 1) % 32; arm = 1'b0;
        check("rearm_err.se0", int'(se0), 0);
        check("rearm_err.busy0", int'(busy0), 1);

        // Reset mid-capture at slot 0o20, mixed = 3*cnt + 1.
        saw = 1'b0;
        for (int n = 0; n < 100; n++) begin
            cnt   = 5'(c);
            mixed = W'(3 * c + 1);
            rst_n = !(saw && c == 15);
            tick();
            c = (c + 1) % 32;
            if (!rst_n) break;
            if (c == 0) saw = 1'b1;
        end
        rst_n = 1'b1;
        check("midrst.fv0", int'(fv0), 0);
        check("midrst.busy0", int'(busy0), 0);
        check("midrst.se0", int'(se0), 0);
        check("midrst.fc0", int'(fc0), 0);
        check("midrst.rd0", int'(rd_data0), 0);
        check("midrst.fc3", int'(fc3), 0);
        for (int k = 0; k < 32; k++) begin
            cnt     = 5'(c);
            rd_addr = 5'(k);
            tick();
            check($sformatf("stale.s0[%0d]", k), int'(rd_data0),
                  (k <= 15) ? 3 * ((k + 31) % 32) + 1 : 3 * (k - 1));
            c = (c + 1) % 32;
        end

        // 256 back-to-back frames wrap frame_cnt.
        frames = 0; prev = 1'b0; arm = 1'b1;
        for (int n = 0; n < 40000 && frames < 256; n++) begin
            cnt     = 5'(c);
            mixed   = W'($urandom);
            rd_addr = 5'($urandom_range(0, 31));
            tick();
            c = (c + 1) % 32;
            if (fv0 && !prev) begin
                frames++;
                if (frames == 255) check("wrap.fc0_255", int'(fc0), 255);
            end
            prev   = fv0;
            arm    = fv0;
            rd_ack = fv0;
        end
        arm = 1'b0; rd_ack = 1'b0;
        check("wrap.frames", frames, 256);
        check("wrap.fc0", int'(fc0), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cnt     = 5'(c);
            mixed   = W'($urandom);
            rd_addr = 5'($urandom_range(0, 31));
            arm     = ($urandom_range(0, 7) == 0);
            rd_ack  = ($urandom_range(0, 3) == 0);
            rst_n   = ($urandom_range(0, 499) != 0);
            tick();
            r = $urandom_range(0, 99);
            if (r == 0) c = $urandom_range(0, 31);
            else if (r != 1) c = (c + 1) % 32;
        end
        rst_n = 1'b1; arm = 1'b0; rd_ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
